// File: rtl/cache_fill_fsm.sv
// Cache block fill sequencer: on a miss, streams NUM_WORDS reads to memory,
// writes returning words into the data array, then commits the tag for one cycle.
module cache_fill_fsm #(
  parameter int NUM_WORDS = 8,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic [15:0]       memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic [ADDR_W-1:0] fill_address,
  output logic [15:0]       fill_data,
  output logic              write_data_array,
  output logic              write_tag_array
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] NW   = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(15);

  typedef enum logic [1:0] {IDLE, FILL, TAG} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]   recv_cnt_q, recv_cnt_d;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          state_d     = FILL;
          base_d      = miss_address & BLK_MASK;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
        end
      end
      FILL: begin
        if (issue_cnt_q < NW) issue_cnt_d = issue_cnt_q + 1'b1;
        if (memory_data_valid) begin
          recv_cnt_d = recv_cnt_q + 1'b1;
          if (recv_cnt_q == LAST) state_d = TAG;
        end
      end
      TAG:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

  // Data-array write follows memory_data_valid in the same cycle, so outputs
  // are decoded from state rather than registered.
  always_comb begin
    fsm_busy         = 1'b0;
    mem_read_en      = 1'b0;
    memory_address   = '0;
    fill_address     = '0;
    fill_data        = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    case (state_q)
      FILL: begin
        fsm_busy         = 1'b1;
        mem_read_en      = (issue_cnt_q < NW);
        if (mem_read_en) memory_address = base_q + ADDR_W'({issue_cnt_q, 1'b0});
        fill_address     = base_q + ADDR_W'({recv_cnt_q, 1'b0});
        fill_data        = memory_data;
        write_data_array = memory_data_valid;
      end
      TAG: begin
        fsm_busy        = 1'b1;
        write_tag_array = 1'b1;
        fill_address    = base_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: in-order memory model with configurable latency and
// a write scoreboard fed from the expected read stream.
module tb_cache_fill_fsm;

  logic        clk, rst, miss_detected, memory_data_valid;
  logic [15:0] miss_address, memory_data;
  logic        fsm_busy, mem_read_en, write_data_array, write_tag_array;
  logic [15:0] memory_address, fill_address, fill_data;

  cache_fill_fsm #(.NUM_WORDS(8), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data(memory_data), .memory_data_valid(memory_data_valid),
    .fsm_busy(fsm_busy), .mem_read_en(mem_read_en), .memory_address(memory_address),
    .fill_address(fill_address), .fill_data(fill_data),
    .write_data_array(write_data_array), .write_tag_array(write_tag_array));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [15:0] addr; logic [15:0] data; } wr_t;
  typedef struct { int rdy; logic [15:0] data; } rd_t;
  typedef struct { logic [15:0] miss_addr; int lat; logic [15:0] exp_base; int exp_tag; } vec_t;

  wr_t exp_q[$];
  rd_t pend[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, rd_idx = 0, lat_fix = 4;
  int n_rd, n_wr, n_tag, first_rd, last_rd, first_wr, last_wr, tag_cyc, tag1, idle_cyc, rd9_cyc;
  int rst_at_wr = 0, rst_cyc = 0;
  logic [15:0] exp_base = '0, nxt_base = '0;
  bit rst_clr = 0, drop_miss = 0, hold_miss = 0, force_vld = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", nm, cyc);
  endtask

  task automatic clr_stats();
    n_rd = 0; n_wr = 0; n_tag = 0; first_rd = -1; last_rd = -1; first_wr = -1;
    last_wr = -1; tag_cyc = -1; tag1 = -1; idle_cyc = -1; rd9_cyc = -1; rd_idx = 0;
  endtask

  task automatic sample();
    logic [15:0] ea;
    int l;
    wr_t e;
    if (mem_read_en) begin
      ea = exp_base + 16'(2 * rd_idx);
      chk("rd_addr", memory_address, ea);
      l = (lat_fix > 0) ? lat_fix : int'($urandom_range(6, 1));
      pend.push_back('{rdy: cyc + l, data: 16'hA000 + 16'(rd_idx)});
      exp_q.push_back('{addr: ea, data: 16'hA000 + 16'(rd_idx)});
      rd_idx++; n_rd++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
      if (n_rd == 9) rd9_cyc = cyc;
    end
    if (write_data_array) begin
      n_wr++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      if (exp_q.size() == 0) fail_now("wr_unexpected");
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", fill_address, e.addr);
        chk("wr_data", fill_data, e.data);
      end
    end
    if (write_tag_array) begin
      n_tag++;
      tag_cyc = cyc;
      if (n_tag == 1) tag1 = cyc;
      chk("tag_addr", fill_address, exp_base);
      if (hold_miss) begin
        hold_miss = 0; exp_base = nxt_base; rd_idx = 0;
      end else drop_miss = 1;
    end
    if (!fsm_busy) begin
      chk("idle_outs", {mem_read_en, write_data_array, write_tag_array, 13'b0,
                        memory_address | fill_address | fill_data}, 32'h0);
      if (idle_cyc < 0 && cyc > 0) idle_cyc = cyc;
    end
    // Abort lands on the edge that accepts this write.
    if (rst_at_wr > 0 && write_data_array && n_wr == rst_at_wr) begin
      rst = 1'b1; rst_clr = 1; rst_cyc = cyc; rst_at_wr = 0;
      exp_q.delete(); drop_miss = 1;
    end
  endtask

  task automatic tick();
    rd_t r;
    @(posedge clk); #1;
    cyc++;
    if (rst_clr) begin rst = 1'b0; rst_clr = 0; end
    if (drop_miss) begin miss_detected = 1'b0; drop_miss = 0; end
    memory_data_valid = 1'b0;
    memory_data = '0;
    if (force_vld) begin
      memory_data_valid = 1'b1; memory_data = 16'($urandom);
    end else if (pend.size() > 0 && pend[0].rdy <= cyc) begin
      r = pend.pop_front();
      memory_data_valid = 1'b1; memory_data = r.data;
    end
    @(negedge clk);
    sample();
  endtask

  // Called just after a negedge: the current cycle is numbered 0, its closing edge samples the miss.
  task automatic start_miss(input logic [15:0] a, input logic [15:0] b, input int lat);
    clr_stats();
    exp_base = b; lat_fix = lat; cyc = 0;
    miss_detected = 1'b1; miss_address = a;
  endtask

  task automatic run_fill(input vec_t v);
    start_miss(v.miss_addr, v.exp_base, v.lat);
    for (int i = 0; i < 120 && idle_cyc < 0; i++) tick();
    if (idle_cyc < 0) fail_now("fill_timeout");
    chk("fill_reads", n_rd, 8);
    chk("fill_writes", n_wr, 8);
    chk("fill_tags", n_tag, 1);
    chk("fill_first_rd", first_rd, 1);
    chk("fill_idle_after_tag", idle_cyc, tag_cyc + 1);
    if (v.exp_tag > 0) begin
      chk("fill_last_rd", last_rd, 8);
      chk("fill_first_wr", first_wr, v.exp_tag - 8);
      chk("fill_last_wr", last_wr, v.exp_tag - 1);
      chk("fill_tag_cyc", tag_cyc, v.exp_tag);
    end
    repeat (3) tick();
    chk("fill_sb_empty", exp_q.size(), 0);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{miss_addr: 16'h1236, lat: 4, exp_base: 16'h1230, exp_tag: 13};
    vecs[1] = '{miss_addr: 16'h5A5C, lat: 0, exp_base: 16'h5A50, exp_tag: 0};
    vecs[2] = '{miss_addr: 16'hFFFA, lat: 2, exp_base: 16'hFFF0, exp_tag: 11};
    vecs[3] = '{miss_addr: 16'h000F, lat: 1, exp_base: 16'h0000, exp_tag: 10};
    vecs[4] = '{miss_addr: 16'h8001, lat: 0, exp_base: 16'h8000, exp_tag: 0};

    rst = 1'b1; miss_detected = 1'b0; miss_address = '0;
    memory_data = '0; memory_data_valid = 1'b0;
    clr_stats();
    tick();
    rst_clr = 1;
    tick();
    chk("rst_busy", fsm_busy, 0);

    // Stray valids in IDLE
    force_vld = 1;
    repeat (3) begin
      tick();
      chk("stray_wr", write_data_array, 0);
      chk("stray_busy", fsm_busy, 0);
    end
    force_vld = 0;
    tick();
    chk("stray_busy_after", fsm_busy, 0);

    foreach (vecs[k]) run_fill(vecs[k]);

    // Reset after the third data write while memory keeps answering
    start_miss(16'h2224, 16'h2220, 4);
    rst_at_wr = 3;
    for (int i = 0; i < 40 && rst_cyc == 0; i++) tick();
    if (rst_cyc == 0) fail_now("abort_no_reset");
    repeat (15) tick();
    chk("abort_idle_cyc", idle_cyc, rst_cyc + 1);
    chk("abort_writes", n_wr, 3);
    chk("abort_tags", n_tag, 0);
    chk("abort_pend_drained", pend.size(), 0);

    // Back-to-back: miss held through TAG, address changed mid-fill
    start_miss(16'h7772, 16'h7770, 3);
    hold_miss = 1; nxt_base = 16'h4000;
    for (int i = 0; i < 150 && n_tag < 2; i++) begin
      tick();
      if (cyc == 3) miss_address = 16'h4000;
    end
    if (n_tag < 2) fail_now("b2b_timeout");
    repeat (4) tick();
    chk("b2b_tag1", tag1, 12);
    chk("b2b_idle", idle_cyc, tag1 + 1);
    chk("b2b_rd2_start", rd9_cyc, tag1 + 2);
    chk("b2b_reads", n_rd, 16);
    chk("b2b_writes", n_wr, 16);
    chk("b2b_busy_end", fsm_busy, 0);
    chk("b2b_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
